elastic_skid_buffer: RTL and testbench

//  Parametrised valid/ready pipeline buffer with a registered ready_o: ready_o never depends

---
 rtl/elastic_skid_buffer.sv | 119 +++++++++++
 tb/tb_elastic_skid_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_skid_buffer.sv
// Elastic valid/ready buffer with a registered ready_o.
// DEPTH-entry circular store; OUT_REG selects a bypass (0-cycle) or registered (1-cycle) output.
module elastic_skid_buffer #(
    parameter int DW      = 8,
    parameter int DEPTH   = 2,
    parameter int OUT_REG = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DW-1:0]                data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DW-1:0]                data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(DEPTH+1)-1:0]   peak_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] peak_q, peak_d;
    logic          ready_q, ready_d;

    logic          empty;
    logic          push;
    logic          pop;
    logic          store;   // beat written into storage this cycle
    logic          unload;  // head entry leaves storage this cycle
    logic [DW-1:0] head;

    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign push  = valid_i & ready_q;
    assign pop   = valid_o & ready_i;

    generate
        if (OUT_REG == 0) begin : g_bypass
            // Empty buffer passes upstream straight through; a beat taken downstream
            // the same cycle never touches storage.
            always_comb begin
                valid_o = empty ? valid_i : 1'b1;
                data_o  = empty ? data_i  : head;
                store   = push & ~(empty & ready_i);
                unload  = pop & ~empty;
            end
        end else begin : g_reg
            // Output always comes from storage, so every beat is stored first.
            always_comb begin
                valid_o = ~empty;
                data_o  = empty ? '0 : head;
                store   = push;
                unload  = pop;
            end
        end
    endgenerate

    // Next-state for storage, pointers, occupancy, peak and the registered ready.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;
        ready_d  = ready_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
            ready_d  = 1'b1;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (unload) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(store) - CW'(unload);
            peak_d  = (count_d > peak_q) ? count_d : peak_q;
            // ready looks at next occupancy only, never at ready_i
            ready_d = (count_d < DEPTH_C);
        end
    end

    // State registers; reset empties the buffer and zeroes storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign count_o = count_q;
    assign peak_o  = peak_q;

endmodule

// File: tb/tb_elastic_skid_buffer.sv
// Bench for elastic_skid_buffer: four configurations share one input stream and are
// checked each cycle against a queue-level model, plus a vector table and directed cases.
module tb_elastic_skid_buffer;

    logic       clk = 1'b0;
    logic       rst, clr, vi, rdy;
    logic [7:0] di;

    // A: OUT_REG=1 DEPTH=2   B: OUT_REG=1 DEPTH=4   C: OUT_REG=0 DEPTH=1   D: OUT_REG=0 DEPTH=3
    logic       vo_a, ro_a, vo_b, ro_b, vo_c, ro_c, vo_d, ro_d;
    logic [7:0] dout_a, dout_b, dout_c, dout_d;
    logic [1:0] cnt_a, pk_a, cnt_d, pk_d;
    logic [2:0] cnt_b, pk_b;
    logic [0:0] cnt_c, pk_c;

    always #5 clk = ~clk;

    elastic_skid_buffer #(.DW(8), .DEPTH(2), .OUT_REG(1)) u_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vi), .ready_o(ro_a), .data_i(di),
        .valid_o(vo_a), .ready_i(rdy), .data_o(dout_a), .count_o(cnt_a), .peak_o(pk_a));
    elastic_skid_buffer #(.DW(8), .DEPTH(4), .OUT_REG(1)) u_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vi), .ready_o(ro_b), .data_i(di),
        .valid_o(vo_b), .ready_i(rdy), .data_o(dout_b), .count_o(cnt_b), .peak_o(pk_b));
    elastic_skid_buffer #(.DW(8), .DEPTH(1), .OUT_REG(0)) u_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vi), .ready_o(ro_c), .data_i(di),
        .valid_o(vo_c), .ready_i(rdy), .data_o(dout_c), .count_o(cnt_c), .peak_o(pk_c));
    elastic_skid_buffer #(.DW(8), .DEPTH(3), .OUT_REG(0)) u_d (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vi), .ready_o(ro_d), .data_i(di),
        .valid_o(vo_d), .ready_i(rdy), .data_o(dout_d), .count_o(cnt_d), .peak_o(pk_d));

    int total = 0;
    int bad   = 0;

    // Reference model: contents held as a list with the oldest beat at index 0.
    int         dep [4] = '{2, 4, 1, 3};
    int         oreg[4] = '{1, 1, 0, 0};
    logic [7:0] mq  [4][8];
    int         msz [4];
    bit         mrdy[4];
    int         mpk [4];
    bit         evo [4];
    int         edo [4];

    typedef struct {
        bit         c, v, r;
        logic [7:0] d;
        bit         evo, ero;
        logic [7:0] edo;
        int         ecnt, epk;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            msz[k] = 0; mrdy[k] = 1'b1; mpk[k] = 0;
        end
    endtask

    task automatic get_act(input int k, output int v, output int d, output int r,
                           output int c, output int p);
        case (k)
            0: begin v = int'(vo_a); d = int'(dout_a); r = int'(ro_a); c = int'(cnt_a); p = int'(pk_a); end
            1: begin v = int'(vo_b); d = int'(dout_b); r = int'(ro_b); c = int'(cnt_b); p = int'(pk_b); end
            2: begin v = int'(vo_c); d = int'(dout_c); r = int'(ro_c); c = int'(cnt_c); p = int'(pk_c); end
            default: begin v = int'(vo_d); d = int'(dout_d); r = int'(ro_d); c = int'(cnt_d); p = int'(pk_d); end
        endcase
    endtask

    // Mid-cycle check of every DUT against the model's view of this cycle.
    task automatic sample();
        int v, d, r, c, p;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (oreg[k] == 0 && msz[k] == 0) begin
                evo[k] = vi; edo[k] = int'(di);
            end else begin
                evo[k] = (msz[k] != 0);
                edo[k] = (msz[k] != 0) ? int'(mq[k][0]) : 0;
            end
            get_act(k, v, d, r, c, p);
            chk($sformatf("d%0d.valid_o", k), v, int'(evo[k]));
            chk($sformatf("d%0d.data_o", k), d, edo[k]);
            chk($sformatf("d%0d.ready_o", k), r, int'(mrdy[k]));
            chk($sformatf("d%0d.count_o", k), c, msz[k]);
            chk($sformatf("d%0d.peak_o", k), p, mpk[k]);
        end
    endtask

    // Apply this cycle's transfer rules to the model, then move past the clock edge.
    task automatic advance();
        bit push, pop, bypass;
        for (int k = 0; k < 4; k++) begin
            if (clr) begin
                msz[k] = 0; mrdy[k] = 1'b1; mpk[k] = 0;
            end else begin
                push   = vi & mrdy[k];
                pop    = evo[k] & rdy;
                bypass = (oreg[k] == 0) && (msz[k] == 0) && rdy;
                if (pop && msz[k] > 0) begin
                    for (int j = 0; j < msz[k] - 1; j++) mq[k][j] = mq[k][j+1];
                    msz[k]--;
                end
                if (push && !bypass) begin
                    mq[k][msz[k]] = di;
                    msz[k]++;
                end
                mrdy[k] = (msz[k] < dep[k]);
                if (msz[k] > mpk[k]) mpk[k] = msz[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; vi = 1'b0; rdy = 1'b0; di = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vi = 1'b0; rdy = 1'b0; di = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table for A (OUT_REG=1, DEPTH=2): reset state, fill, stall, drain,
        // push+pop at count=DEPTH-1, clear resets peak.
        //            c  v  r  d      evo ero edo    cnt pk
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'h00, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 1, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h11, 2, 2};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h11, 2, 2};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1, 2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h33, 1, 2};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 0, 2};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 8'h00, 0, 2};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0};
        for (int i = 0; i < 10; i++) begin
            clr = tbl[i].c; vi = tbl[i].v; rdy = tbl[i].r; di = tbl[i].d;
            sample();
            chk($sformatf("tbl%0d.valid_o", i), int'(vo_a), int'(tbl[i].evo));
            chk($sformatf("tbl%0d.ready_o", i), int'(ro_a), int'(tbl[i].ero));
            chk($sformatf("tbl%0d.data_o", i), int'(dout_a), int'(tbl[i].edo));
            chk($sformatf("tbl%0d.count_o", i), int'(cnt_a), tbl[i].ecnt);
            chk($sformatf("tbl%0d.peak_o", i), int'(pk_a), tbl[i].epk);
            advance();
        end
        clr = 1'b0;

        // Streaming 0x01..0x10 through A with ready_i=1: one-cycle latency, never stalls.
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            vi = (i < 16); di = 8'(i + 1);
            sample();
            chk("stream.ready_o", int'(ro_a), 1);
            chk("stream.count_le1", int'(cnt_a <= 2'd1), 1);
            if (i > 0) chk("stream.data_o", int'(dout_a), i);
            advance();
        end

        // Fill B (DEPTH=4) while stalled, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vi = 1'b1; di = 8'hA0 + 8'(i);
            sample();
            advance();
        end
        vi = 1'b0;
        sample();
        chk("fill.count_o", int'(cnt_b), 4);
        chk("fill.ready_o", int'(ro_b), 0);
        chk("fill.peak_o", int'(pk_b), 4);
        advance();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("drain.data_o", int'(dout_b), 'hA0 + i);
            if (i == 1) chk("drain.ready_o", int'(ro_b), 1);
            advance();
        end

        // Clear with three beats stored and a push attempted in the clear cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vi = 1'b1; di = 8'h31 + 8'(i);
            sample();
            advance();
        end
        clr = 1'b1; vi = 1'b1; di = 8'hEE;
        sample();
        chk("clr.pre_count", int'(cnt_b), 3);
        advance();
        clr = 1'b0; vi = 1'b0;
        sample();
        chk("clr.count_o", int'(cnt_b), 0);
        chk("clr.peak_o", int'(pk_b), 0);
        chk("clr.ready_o", int'(ro_b), 1);
        chk("clr.valid_o", int'(vo_b), 0);
        advance();
        rdy = 1'b1;
        repeat (3) begin
            sample();
            chk("clr.no_ghost", int'(vo_b), 0);
            advance();
        end

        // Classic skid on C (OUT_REG=0, DEPTH=1).
        do_reset();
        vi = 1'b1; di = 8'h55; rdy = 1'b1;
        sample();
        chk("skid.bypass_valid", int'(vo_c), 1);
        chk("skid.bypass_data", int'(dout_c), 'h55);
        advance();
        di = 8'h66; rdy = 1'b0;
        sample();
        chk("skid.ready_before", int'(ro_c), 1);
        advance();
        repeat (2) begin
            sample();
            chk("skid.ready_low", int'(ro_c), 0);
            chk("skid.held_data", int'(dout_c), 'h66);
            chk("skid.count_o", int'(cnt_c), 1);
            advance();
        end
        rdy = 1'b1;
        sample();
        chk("skid.pop_data", int'(dout_c), 'h66);
        advance();
        vi = 1'b0;
        sample();
        chk("skid.ready_back", int'(ro_c), 1);
        chk("skid.count_zero", int'(cnt_c), 0);
        advance();

        // Randomized traffic with varying backpressure, occasional clears, one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            clr = ($urandom_range(0, 63) == 0);
            vi  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 7) < ((i / 300) % 8 + 1));
            di  = 8'($urandom_range(0, 255));
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
